// File: rtl/rns_modaddsub_pkg.sv
// Shared definitions for the RNS modular add/subtract pipeline: op encoding
// and default channel geometry.
package rns_modaddsub_pkg;

  // Operation select carried with each beat.
  localparam logic RNS_OP_SUB = 1'b0;
  localparam logic RNS_OP_ADD = 1'b1;

  // Default geometry: residue/modulus width and number of channels.
  localparam int unsigned RNS_DEF_W   = 3;
  localparam int unsigned RNS_DEF_NCH = 3;

endpackage

// File: rtl/rns_mod_lane.sv
// One RNS channel of the modular add/subtract pipeline.
//   Stage 1: modular complement of b (subtract only), t = a + b' in W+1 bits,
//            range-error detection; registers t, m, err when s1_en.
//   Stage 2: conditional subtract of m; registers r, err when s2_en.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   s1_en, s2_en  stage load enables from the top-level flow control
//   op            RNS_OP_SUB / RNS_OP_ADD
//   a, b, m       operand residues and modulus (W bits)
//   r             registered result residue (W bits)
//   err           registered channel error (a>=m | b>=m | m<2)
module rns_mod_lane
  import rns_modaddsub_pkg::*;
#(
  parameter int unsigned W = RNS_DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s1_en,
  input  logic         s2_en,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] r,
  output logic         err
);

  localparam int unsigned TW = W + 1;

  logic [W-1:0]  b_cmp;
  logic [TW-1:0] t_d;
  logic          err_d;

  logic [TW-1:0] t_q;
  logic [W-1:0]  m_q;
  logic          err1_q;

  logic [W-1:0]  r_d;
  logic [W-1:0]  r_q;
  logic          err2_q;

  // Stage 1: subtract becomes add of the modular complement (m-b, or 0 for b==0),
  // so a valid sum never exceeds 2m-2 and fits in W+1 bits.
  always_comb begin
    b_cmp = b;
    if (op == RNS_OP_SUB) begin
      b_cmp = (b == '0) ? '0 : W'(m - b);
    end
    t_d   = TW'(a) + TW'(b_cmp);
    err_d = (a >= m) | (b >= m) | (m < W'(2));
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q    <= '0;
      m_q    <= '0;
      err1_q <= 1'b0;
    end else if (s1_en) begin
      t_q    <= t_d;
      m_q    <= m;
      err1_q <= err_d;
    end
  end

  // Stage 2: single conditional subtract brings t into 0..m-1.
  always_comb begin
    r_d = W'(t_q);
    if (t_q >= TW'(m_q)) begin
      r_d = W'(t_q - TW'(m_q));
    end
  end

  // Stage 2 registers; held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      err2_q <= 1'b0;
    end else if (s2_en) begin
      r_q    <= r_d;
      err2_q <= err1_q;
    end
  end

  assign r   = r_q;
  assign err = err2_q;

endmodule

// File: rtl/rns_modaddsub_pipe.sv
// Multi-channel RNS modular adder/subtractor, two pipeline stages with
// valid/ready flow control. Channel i computes (a_i -/+ b_i) mod m_i.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input beat handshake
//   op                   0 = subtract, 1 = add (sampled with beat)
//   res_a, res_b         operand residues, NCH*W, channel 0 in LSBs
//   moduli               per-channel modulus, NCH*W (sampled with beat)
//   out_valid, out_ready result handshake
//   out_res              result residues, NCH*W
//   out_err              per-channel range-error flags, NCH
module rns_modaddsub_pipe
  import rns_modaddsub_pkg::*;
#(
  parameter int unsigned W   = RNS_DEF_W,
  parameter int unsigned NCH = RNS_DEF_NCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [NCH*W-1:0] res_a,
  input  logic [NCH*W-1:0] res_b,
  input  logic [NCH*W-1:0] moduli,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH*W-1:0] out_res,
  output logic [NCH-1:0]   out_err
);

  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  // Each stage advances when its successor is empty or advancing.
  assign s2_adv   = !s2_valid | out_ready;
  assign in_ready = !s1_valid | s2_adv;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid & s2_adv;

  // Stage occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
    end
  end

  assign out_valid = s2_valid;

  // Independent per-channel datapaths sharing the stage enables.
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    rns_mod_lane #(
      .W (W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .s1_en (s1_load),
      .s2_en (s2_load),
      .op    (op),
      .a     (res_a[g*W +: W]),
      .b     (res_b[g*W +: W]),
      .m     (moduli[g*W +: W]),
      .r     (out_res[g*W +: W]),
      .err   (out_err[g])
    );
  end

endmodule
